// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmit path among
// NUM_REQ requesters. The winner's word is latched and announced with a start
// pulse. The frame then waits for a rising edge on tx_done_i, or aborts after
// TIMEOUT cycles.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable_i       1 = new grants allowed; 0 = finish current frame, then idle
//   req_valid_i    per-requester word valid
//   req_data_i     packed words, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o    one-hot accept strobe to the winner (same-cycle, IDLE only)
//   tx_done_i      UART transmit-done level; completion is its rising edge
//   tx_data_o      latched word for the UART TX data register
//   start_tx_o     one-cycle start pulse (registered, high only in SEND)
//   busy_o         high while not IDLE (registered)
//   grant_id_o     index of current/last granted requester
//   done_o         one-cycle pulse on normal completion
//   timeout_o      one-cycle pulse on timeout abort
//
// req_ready_o, done_o and timeout_o are decoded in the cycle of the event.
// The decode uses registered state and tx_done_q, so the handshake and
// edge-detect latencies stay at a single cycle.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic                              tx_done_i,
  output logic [DATA_W-1:0]                 tx_data_o,
  output logic                              start_tx_o,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id_o,
  output logic                              done_o,
  output logic                              timeout_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic             any_win;
  logic             grant;
  logic             tx_done_q;
  logic             done_edge;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    winner  = '0;
    any_win = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!any_win && req_valid_i[idx]) begin
        any_win = 1'b1;
        winner  = idx;
      end
    end
  end

  // reset_n gating keeps the accept strobe low while reset is held
  assign grant       = (state == IDLE) && enable_i && reset_n && any_win;
  assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;

  assign done_edge = tx_done_i & ~tx_done_q;
  assign cnt_hit   = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Next state and completion pulses; done takes priority over timeout
  always_comb begin
    state_n   = state;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) state_n = SEND;
      end
      SEND: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_edge) begin
          done_o  = 1'b1;
          state_n = IDLE;
        end else if (cnt_hit) begin
          timeout_o = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_RST;
      tx_done_q  <= 1'b1;
      cnt        <= '0;
      tx_data_o  <= '0;
      grant_id_o <= '0;
      start_tx_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      tx_done_q  <= tx_done_i;
      start_tx_o <= (state_n == SEND);
      busy_o     <= (state_n != IDLE);
      if (grant) begin
        tx_data_o  <= req_data_i[32'(winner)*DATA_W +: DATA_W];
        grant_id_o <= winner;
        rr_ptr     <= winner;
      end
      if (state == SEND) begin
        cnt <= '0;
      end else if (state == WAIT_DONE) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
